// File: rtl/ring_freq_meter.sv
// Gated BCD frequency counter for the ring-oscillator output, feeding the 4-digit display.
// Optional build macro FREQ_METER_SAT_EN: saturate at 9999 and report it on ovf.
`timescale 1ns/1ps

module ring_freq_meter #(
    parameter int GATE_SHORT = 50000,
    parameter int GATE_LONG  = 50000000,
    parameter int GW         = 26
) (
    input  logic        fpga_clk1,
    input  logic        rst_n,
    input  logic        Mode,
    input  logic        Stress,
    input  logic        ring_out,
    output logic [15:0] bcd,
    output logic        valid,
    output logic        busy
`ifdef FREQ_METER_SAT_EN
    ,
    output logic        ovf
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_GATE  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam logic [GW-1:0] LP_SHORT_LAST = GW'(GATE_SHORT - 1);
    localparam logic [GW-1:0] LP_LONG_LAST  = GW'(GATE_LONG - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic          w_rise;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [GW-1:0] r_gate;
    logic          w_gate_done;
    logic          w_count;

    logic [15:0]   r_work;
    logic [15:0]   w_work_inc;
    logic [15:0]   r_bcd;
    logic          r_valid;
    logic          r_busy;

    // Two flops bring ring_out into fpga_clk1; the third only remembers the previous level.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= ring_out;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise      = r_s2 & ~r_s3;
    assign w_gate_done = (r_gate == '0);
    assign w_count     = (r_state == ST_GATE) & w_rise;

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Stress) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                w_state_nxt = Stress ? ST_GATE : ST_IDLE;
            end
            ST_GATE: begin
                if (!Stress) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_gate_done) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_state_nxt = Stress ? ST_ARM : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Mode is only looked at here, so a change mid-window waits for the next ARM.
    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_gate <= '0;
        end else if (r_state == ST_ARM) begin
            r_gate <= Mode ? LP_LONG_LAST : LP_SHORT_LAST;
        end else if ((r_state == ST_GATE) && !w_gate_done) begin
            r_gate <= r_gate - GW'(1);
        end
    end

    // Ripple BCD increment: each digit rolls 9->0 and passes the carry upward.
    always_comb begin
        logic v_carry;
        w_work_inc = r_work;
        v_carry    = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (v_carry) begin
                if (r_work[4*d +: 4] == 4'd9) begin
                    w_work_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_work_inc[4*d +: 4] = r_work[4*d +: 4] + 4'd1;
                    v_carry              = 1'b0;
                end
            end
        end
    end

`ifdef FREQ_METER_SAT_EN
    logic r_sat;
    logic r_ovf;
    logic w_work_full;

    assign w_work_full = (r_work == 16'h9999);

    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= 16'h0000;
            r_sat  <= 1'b0;
        end else if (r_state == ST_ARM) begin
            r_work <= 16'h0000;
            r_sat  <= 1'b0;
        end else if (w_count) begin
            if (w_work_full) begin
                r_sat  <= 1'b1;
            end else begin
                r_work <= w_work_inc;
            end
        end
    end

    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_LATCH) begin
            r_ovf <= r_sat;
        end
    end

    assign ovf = r_ovf;
`else
    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= 16'h0000;
        end else if (r_state == ST_ARM) begin
            r_work <= 16'h0000;
        end else if (w_count) begin
            r_work <= w_work_inc;
        end
    end
`endif

    // An aborted window never reaches LATCH, so bcd keeps the last good result.
    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd   <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_LATCH);
            if (r_state == ST_LATCH) begin
                r_bcd <= r_work;
            end
        end
    end

    assign bcd   = r_bcd;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule
